// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - Register offsets (word index taken from mem_addr[3:2])
//   - STATUS register bit positions
//   - Transmit FSM state encoding
//   - Helper that saturates the FIFO occupancy into the 4-bit STATUS count field
package uart_tx_mmio_pkg;

  // Register offsets (word index within the IO page)
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // STATUS register layout
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 4;

  // Transmit FSM states
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // FIFO count as shown in STATUS; deeper FIFOs would not fit in 4 bits, so clamp at 15.
  function automatic logic [STAT_CNT_W-1:0] sat_count4(input logic [31:0] cnt);
    return (cnt > 32'd15) ? 4'hF : cnt[STAT_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used as the UART transmit buffer.
//   clk, resetn : clock and asynchronous active-low reset (pointers/count cleared)
//   push_i      : write din_i; accepted when not full, or when full and popped in the same cycle
//   pop_i       : remove the head entry; ignored while empty
//   din_i       : write data
//   dout_o      : current head entry (valid while !empty_o)
//   full_o      : FIFO holds DEPTH entries
//   empty_o     : FIFO holds no entries
//   count_o     : number of entries held (0..DEPTH)
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still safe when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly AW bits wide so they wrap at DEPTH on their own.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the processor memory bus.
// Bytes stored to DATA are queued in a FIFO and shifted out LSB first on tx.
// STATUS reports busy/full/empty/overflow and the FIFO count for polling.
//   clk        : system clock
//   resetn     : asynchronous active-low reset
//   mem_addr   : byte address; bit IO_BIT selects the IO page, [3:2] the register
//   mem_wdata  : store data; [7:0] is the byte pushed on a DATA write
//   mem_wmask  : byte enables; a DATA push needs mem_wmask[0]
//   mem_rstrb  : read strobe
//   mem_rdata  : registered read data (1-cycle latency, holds otherwise)
//   tx         : serial output, idle high
//   irq        : registered "all sent" flag (FIFO empty and transmitter idle)
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned IO_BIT       = 22
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [3:0]      mem_wmask,
  input  logic            mem_rstrb,
  output logic [XLEN-1:0] mem_rdata,
  output logic            tx,
  output logic            irq
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       sel;
  logic [1:0] reg_off;
  logic       wr_data;
  logic       rd_en;
  logic       rd_status;

  assign sel       = mem_addr[IO_BIT];
  assign reg_off   = mem_addr[3:2];
  assign wr_data   = sel && (reg_off == REG_DATA) && mem_wmask[0];
  assign rd_en     = sel && mem_rstrb;
  assign rd_status = rd_en && (reg_off == REG_STATUS);

  // Address/data bits outside the decoded fields are intentionally ignored.
  logic unused_bus;
  assign unused_bus = ^{mem_addr, mem_wdata[XLEN-1:8], mem_wmask[3:1]};

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic            fifo_pop;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (wr_data),
    .pop_i   (fifo_pop),
    .din_i   (mem_wdata[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             irq_q, irq_d;
  logic             overflow_q, overflow_d;
  logic [XLEN-1:0]  mem_rdata_q, mem_rdata_d;

  logic             baud_last;
  logic             ovf_set;
  logic [XLEN-1:0]  status;

  assign baud_last = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  // ---------------------------------------------------------------------------
  // Transmit FSM next state; tx_d is the level for the cycle after this edge
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          tx_d     = 1'b0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            // Next bit is the one about to land in shift[0].
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // STATUS, overflow, read data, irq
  // ---------------------------------------------------------------------------
  always_comb begin
    status                                = '0;
    status[STAT_BUSY]                     = (state_q != StIdle);
    status[STAT_FULL]                     = fifo_full;
    status[STAT_EMPTY]                    = fifo_empty;
    status[STAT_OVF]                      = overflow_q;
    status[STAT_CNT_LSB +: STAT_CNT_W]    = sat_count4(32'(fifo_count));
  end

  // A dropped push outranks the clear-on-read of the same cycle.
  assign ovf_set = wr_data && fifo_full && !fifo_pop;

  always_comb begin
    overflow_d  = ovf_set | (overflow_q & ~rd_status);
    irq_d       = fifo_empty && (state_q == StIdle);
    mem_rdata_d = mem_rdata_q;
    if (rd_en) begin
      mem_rdata_d = rd_status ? status : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      irq_q       <= 1'b1;
      overflow_q  <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      irq_q       <= irq_d;
      overflow_q  <= overflow_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign tx        = tx_q;
  assign irq       = irq_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// A cycle-level transaction model predicts accepted bytes, STATUS, read data and irq;
// a serial monitor decodes tx independently and the decoded stream is compared
// against the model's transmit order.
module tb_uart_tx_mmio;

  localparam int CB  = 4;
  localparam int D   = 8;
  localparam int IOB = 22;
  localparam logic [31:0] IO_BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        tx;
  logic        irq;

  uart_tx_mmio #(
    .XLEN         (32),
    .CLKS_PER_BIT (CB),
    .FIFO_DEPTH   (D),
    .IO_BIT       (IOB)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .tx        (tx),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Reference model: byte queue plus transmitter occupancy in time
  // ---------------------------------------------------------------------------
  logic [7:0]  mq[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int          m_cyc;
  int          last_pop;
  logic        m_ovf;
  logic [31:0] exp_rdata;
  logic        exp_irq;

  function automatic logic model_busy();
    // A frame occupies the 10*CB edges after the pop edge.
    return (m_cyc > last_pop) && (m_cyc <= last_pop + 10 * CB);
  endfunction

  task automatic model_step();
    logic        sel;
    logic [1:0]  off;
    logic        busy;
    logic        wr;
    logic        rds;
    logic [31:0] st;
    int          sz;
    sel  = mem_addr[IOB];
    off  = mem_addr[3:2];
    busy = model_busy();
    sz   = mq.size();
    st   = 32'd0;
    st[0] = busy;
    st[1] = (sz == D);
    st[2] = (sz == 0);
    st[3] = m_ovf;
    st[7:4] = 4'((sz > 15) ? 15 : sz);
    exp_irq = (sz == 0) && !busy;
    if (sel && mem_rstrb) exp_rdata = (off == 2'd1) ? st : 32'd0;
    if (!busy && sz != 0) begin
      exp_q.push_back(mq.pop_front());
      last_pop = m_cyc;
    end
    wr  = sel && (off == 2'd0) && mem_wmask[0];
    rds = sel && mem_rstrb && (off == 2'd1);
    if (wr && mq.size() < D) mq.push_back(mem_wdata[7:0]);
    if (wr && mq.size() >= D && !(mq.size() == D && mq[D-1] == mem_wdata[7:0] && 0)) begin
    end
    m_cyc++;
  endtask

  task automatic tick();
    logic wr_full;
    wr_full = mem_addr[IOB] && (mem_addr[3:2] == 2'd0) && mem_wmask[0];
    // Overflow decision needs the post-pop occupancy, so evaluate it around the step.
    begin
      int pre_sz;
      logic busy;
      logic rds;
      busy   = model_busy();
      pre_sz = mq.size();
      rds    = mem_addr[IOB] && mem_rstrb && (mem_addr[3:2] == 2'd1);
      if (!busy && pre_sz != 0) pre_sz = pre_sz - 1;
      model_step();
      if (wr_full && pre_sz >= D) m_ovf = 1'b1;
      else if (rds) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
    mem_addr  = addr;
    mem_wdata = data;
    mem_wmask = mask;
    mem_rstrb = 1'b0;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] addr);
    mem_addr  = addr;
    mem_wmask = '0;
    mem_rstrb = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic do_reset();
    bus_idle();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    mq.delete();
    exp_q.delete();
    rx_q.delete();
    m_cyc     = 0;
    last_pop  = -1000;
    m_ovf     = 1'b0;
    exp_rdata = '0;
    exp_irq   = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (rx_q.size() >= n);
  endtask

  // ---------------------------------------------------------------------------
  // Serial monitor: samples each bit in its middle; frames cut by reset are dropped
  // ---------------------------------------------------------------------------
  int         rst_count = 0;
  int         ferr = 0;
  int         mon_rc;
  logic       mon_ok;
  logic [7:0] mon_byte;

  always @(negedge resetn) rst_count++;

  always begin
    @(negedge tx);
    mon_rc = rst_count;
    mon_ok = 1'b1;
    repeat (CB / 2) @(posedge clk);
    #1;
    if (tx !== 1'b0) mon_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CB) @(posedge clk);
      #1;
      mon_byte[i] = tx;
    end
    repeat (CB) @(posedge clk);
    #1;
    if (tx !== 1'b1) mon_ok = 1'b0;
    if (mon_rc == rst_count) begin
      if (mon_ok) rx_q.push_back(mon_byte);
      else ferr++;
    end
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    n_tests++;
    if (tx !== 1'b1) begin
      n_fail++; $display("FAIL reset_tx: got %b expected 1", tx);
    end
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL reset_irq: got %b expected 1", irq);
    end
    n_tests++;
    if (mem_rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata);
    end
    bus_read(IO_BASE | 32'h4);
    n_tests++;
    if (mem_rdata !== 32'h4 || mem_rdata !== exp_rdata) begin
      n_fail++; $display("FAIL reset_status: got %h expected 00000004 (model %h)",
                         mem_rdata, exp_rdata);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    logic       eb;
    bit         ok;
    b = 8'h55;
    do_reset();
    bus_write(IO_BASE, 32'h0000_0055, 4'b0001);
    n_tests++;
    if (tx !== 1'b1) begin
      n_fail++; $display("FAIL single_pre_pop_tx: got %b expected 1", tx);
    end
    tick();
    for (int i = 0; i < 10 * CB; i++) begin
      if (i < CB) eb = 1'b0;
      else if (i < 9 * CB) eb = b[(i - CB) / CB];
      else eb = 1'b1;
      n_tests++;
      if (tx !== eb) begin
        n_fail++; $display("FAIL single_tx_cycle%0d: got %b expected %b", i, tx, eb);
      end
      if (i == 5 * CB) begin
        n_tests++;
        if (irq !== 1'b0 || exp_irq !== 1'b0) begin
          n_fail++; $display("FAIL single_irq_mid: got %b expected 0", irq);
        end
      end
      tick();
    end
    tick();
    tick();
    n_tests++;
    if (irq !== 1'b1 || irq !== exp_irq) begin
      n_fail++; $display("FAIL single_irq_end: got %b expected 1", irq);
    end
    wait_rx(1, 50, ok);
    n_tests++;
    if (!ok || rx_q[0] !== 8'h55) begin
      n_fail++; $display("FAIL single_rx: got %0d bytes first %h expected 55", rx_q.size(),
                         (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    for (int i = 0; i < 10; i++) bus_write(IO_BASE, 32'(i), 4'b0001);
    bus_read(IO_BASE | 32'h4);
    n_tests++;
    if (mem_rdata !== 32'h0000_008B || mem_rdata !== exp_rdata) begin
      n_fail++; $display("FAIL ovf_status1: got %h expected 0000008b (model %h)",
                         mem_rdata, exp_rdata);
    end
    bus_read(IO_BASE | 32'h4);
    n_tests++;
    if (mem_rdata !== 32'h0000_0083 || mem_rdata !== exp_rdata) begin
      n_fail++; $display("FAIL ovf_status2: got %h expected 00000083 (model %h)",
                         mem_rdata, exp_rdata);
    end
    wait_rx(9, 600, ok);
    tick();
    n_tests++;
    if (!ok || rx_q.size() != 9) begin
      n_fail++; $display("FAIL ovf_rx_count: got %0d expected 9", rx_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_tests++;
        if (rx_q[i] !== 8'(i)) begin
          n_fail++; $display("FAIL ovf_rx_byte%0d: got %h expected %h", i, rx_q[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_status_read();
    do_reset();
    bus_read(IO_BASE | 32'h4);
    n_tests++;
    if (mem_rdata !== 32'h4) begin
      n_fail++; $display("FAIL status_idle: got %h expected 00000004", mem_rdata);
    end
    repeat (3) tick();
    n_tests++;
    if (mem_rdata !== 32'h4) begin
      n_fail++; $display("FAIL status_hold: got %h expected 00000004", mem_rdata);
    end
    // Non-selected read must not disturb the held value.
    bus_read(32'h0000_0004);
    n_tests++;
    if (mem_rdata !== 32'h4 || mem_rdata !== exp_rdata) begin
      n_fail++; $display("FAIL status_unsel_hold: got %h expected 00000004", mem_rdata);
    end
    bus_read(IO_BASE | 32'h8);
    n_tests++;
    if (mem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL status_off8: got %h expected 0", mem_rdata);
    end
  endtask

  task automatic test_ignored_writes();
    int bad;
    do_reset();
    bus_write(IO_BASE, 32'h0000_00A1, 4'b0010);
    bus_write(32'h0000_0000, 32'h0000_00A2, 4'b0001);
    bus_write(IO_BASE | 32'hC, 32'h0000_00A3, 4'b1111);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL ignored_tx_idle: got %0d low cycles expected 0", bad);
    end
    bus_read(IO_BASE | 32'h4);
    n_tests++;
    if (mem_rdata !== 32'h4) begin
      n_fail++; $display("FAIL ignored_status: got %h expected 00000004", mem_rdata);
    end
    n_tests++;
    if (rx_q.size() != 0) begin
      n_fail++; $display("FAIL ignored_rx: got %0d bytes expected 0", rx_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    bus_write(IO_BASE, 32'h0000_00C3, 4'b0001);
    repeat (1 + CB + 3 * CB) tick();
    resetn = 1'b0;
    #1;
    n_tests++;
    if (tx !== 1'b1) begin
      n_fail++; $display("FAIL midreset_tx: got %b expected 1", tx);
    end
    do_reset();
    repeat (60) tick();
    bus_read(IO_BASE | 32'h4);
    n_tests++;
    if (mem_rdata !== 32'h4) begin
      n_fail++; $display("FAIL midreset_status: got %h expected 00000004", mem_rdata);
    end
    n_tests++;
    if (rx_q.size() != 0 || ferr != 0) begin
      n_fail++; $display("FAIL midreset_rx: got %0d bytes %0d bad frames expected 0 0",
                         rx_q.size(), ferr);
    end
  endtask

  task automatic test_full_pop_push();
    bit ok;
    do_reset();
    for (int i = 0; i < 9; i++) bus_write(IO_BASE, 32'(i), 4'b0001);
    // Next edge is the pop of byte 1 (first pop at edge 1, frames 10*CB+1 edges apart).
    repeat (10 * CB - 7) tick();
    bus_write(IO_BASE, 32'h0000_00A5, 4'b0001);
    bus_read(IO_BASE | 32'h4);
    n_tests++;
    if (mem_rdata !== 32'h0000_0083 || mem_rdata !== exp_rdata) begin
      n_fail++; $display("FAIL fullpop_status: got %h expected 00000083 (model %h)",
                         mem_rdata, exp_rdata);
    end
    wait_rx(10, 700, ok);
    tick();
    n_tests++;
    if (!ok || rx_q.size() != 10 || rx_q[9] !== 8'hA5) begin
      n_fail++; $display("FAIL fullpop_rx: got %0d bytes last %h expected 10 bytes last a5",
                         rx_q.size(), (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'hxx);
    end
  endtask

  task automatic test_random();
    int  r;
    int  k;
    bit  ok;
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      a = $urandom();
      bus_idle();
      if (r <= 3) begin
        mem_addr  = IO_BASE | (a & 32'hFFFF_FFF0);
        mem_wdata = $urandom();
        mem_wmask = ($urandom_range(0, 7) == 0) ? 4'b1110 : 4'(($urandom() | 1) & 4'hF);
      end else if (r == 4) begin
        mem_addr  = a;
        mem_wdata = $urandom();
        mem_wmask = 4'($urandom());
      end else if (r <= 6) begin
        mem_addr  = IO_BASE | (a & 32'hFFFF_FFFC & ~32'h0040_0000) | IO_BASE;
        mem_rstrb = 1'b1;
      end else if (r == 7) begin
        mem_addr  = a & ~IO_BASE;
        mem_rstrb = 1'b1;
      end
      tick();
      bus_idle();
      n_tests++;
      if (mem_rdata !== exp_rdata) begin
        n_fail++; $display("FAIL rand_rdata cyc%0d: got %h expected %h", i, mem_rdata, exp_rdata);
      end
      n_tests++;
      if (irq !== exp_irq) begin
        n_fail++; $display("FAIL rand_irq cyc%0d: got %b expected %b", i, irq, exp_irq);
      end
    end
    k = 0;
    while ((mq.size() != 0 || model_busy()) && k < 2000) begin
      tick();
      k++;
    end
    wait_rx(exp_q.size(), 100, ok);
    tick();
    n_tests++;
    if (!ok || rx_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_rx_count: got %0d expected %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (rx_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_rx_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if (ferr != 0) begin
      n_fail++; $display("FAIL rand_framing: got %0d bad frames expected 0", ferr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_status_read();
    test_ignored_writes();
    test_reset_mid_frame();
    test_full_pop_push();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
